// File: rtl/cpu_cache_ctrl.sv
// Miss-handling FSM for the 256-line direct-mapped data cache (write-back, write-allocate).
// Define CPU_CACHE_STATS_EN to add the saturating hit_cnt / miss_cnt performance counters.
module cpu_cache_ctrl (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_done,
    output logic          cache_en,
    output logic          cache_comp,
    output logic          cache_wr,
    output logic          cache_valid_in,
    output logic          cache_replace_line,
    output logic [7:0]    cache_index,
    output logic [5:0]    cache_offset,
    output logic [17:0]   cache_tag_in,
    output logic [31:0]   cache_data_in,
    output logic [511:0]  cache_cl_in,
    input  logic          cache_hit,
    input  logic          cache_dirty,
    input  logic          cache_valid,
    input  logic [17:0]   cache_tag_out,
    input  logic [31:0]   cache_data_out,
    input  logic [511:0]  cache_cl_out,
    output logic          mem_rd_req,
    output logic          mem_wr_req,
    output logic [31:0]   mem_addr,
    output logic [511:0]  mem_wr_data,
    input  logic [511:0]  mem_rd_data,
    input  logic          mem_rd_valid,
    input  logic          mem_wr_done
`ifdef CPU_CACHE_STATS_EN
    ,
    output logic [31:0]   hit_cnt,
    output logic [31:0]   miss_cnt
`endif
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_COMPARE   = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_FILL      = 3'd3;
    localparam logic [2:0] S_INSTALL   = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic         op_wr_q, op_wr_d;
    logic [31:0]  cpu_rdata_q, cpu_rdata_d;
    logic         cpu_done_q, cpu_done_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [511:0] mem_wr_data_q, mem_wr_data_d;
    logic [511:0] cache_cl_in_q, cache_cl_in_d;
    logic         lookup_hit;
    logic         addr_lsb_unused;

    assign lookup_hit      = cache_hit & cache_valid;
    assign addr_lsb_unused = ^cpu_addr[1:0];

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        op_wr_d       = op_wr_q;
        cpu_rdata_d   = cpu_rdata_q;
        cpu_done_d    = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        cache_cl_in_d = cache_cl_in_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_rd || cpu_wr) begin
                    addr_d  = {cpu_addr[31:2], 2'b00};
                    wdata_d = cpu_wdata;
                    op_wr_d = cpu_wr;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (lookup_hit) begin
                    if (!op_wr_q) begin
                        cpu_rdata_d = cache_data_out;
                    end
                    cpu_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (cache_valid && cache_dirty) begin
                    // Victim address comes from the resident tag, not the request tag.
                    mem_wr_data_d = cache_cl_out;
                    mem_addr_d    = {cache_tag_out, addr_q[13:6], 6'b000000};
                    state_d       = S_WRITEBACK;
                end else begin
                    mem_addr_d = {addr_q[31:6], 6'b000000};
                    state_d    = S_FILL;
                end
            end
            S_WRITEBACK: begin
                if (mem_wr_done) begin
                    mem_addr_d = {addr_q[31:6], 6'b000000};
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_rd_valid) begin
                    cache_cl_in_d = mem_rd_data;
                    state_d       = S_INSTALL;
                end
            end
            S_INSTALL: begin
                state_d = S_COMPARE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            op_wr_q       <= 1'b0;
            cpu_rdata_q   <= '0;
            cpu_done_q    <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            cache_cl_in_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            op_wr_q       <= op_wr_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_done_q    <= cpu_done_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            cache_cl_in_q <= cache_cl_in_d;
        end
    end

    always_comb begin
        cache_en           = (state_q == S_COMPARE) || (state_q == S_INSTALL);
        cache_comp         = (state_q == S_COMPARE);
        cache_wr           = ((state_q == S_COMPARE) && op_wr_q) || (state_q == S_INSTALL);
        cache_replace_line = (state_q == S_INSTALL);
        cache_valid_in     = (state_q == S_INSTALL);
        mem_rd_req         = (state_q == S_FILL);
        mem_wr_req         = (state_q == S_WRITEBACK);
    end

    assign cache_index   = addr_q[13:6];
    assign cache_offset  = addr_q[5:0];
    assign cache_tag_in  = addr_q[31:14];
    assign cache_data_in = wdata_q;
    assign cache_cl_in   = cache_cl_in_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign cpu_done      = cpu_done_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wr_data   = mem_wr_data_q;

`ifdef CPU_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        replay_q, replay_d;

    // replay_q marks the post-INSTALL compare so its guaranteed hit is not counted.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        replay_d   = replay_q;
        if (state_q == S_IDLE) begin
            replay_d = 1'b0;
        end else if (state_q == S_INSTALL) begin
            replay_d = 1'b1;
        end else if (state_q == S_COMPARE) begin
            if (lookup_hit) begin
                if (!replay_q && (hit_cnt_q != '1)) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                end
            end else if (miss_cnt_q != '1) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            replay_q   <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            replay_q   <= replay_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_cache_ctrl.sv
// Directed bench for cpu_cache_ctrl with a behavioural cache array and memory responder.
// Counter checks are included only when CPU_CACHE_STATS_EN is defined.
module tb_cpu_cache_ctrl;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_rd, cpu_wr;
    logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
    logic          cpu_done;
    logic          cache_en, cache_comp, cache_wr, cache_valid_in, cache_replace_line;
    logic [7:0]    cache_index;
    logic [5:0]    cache_offset;
    logic [17:0]   cache_tag_in;
    logic [31:0]   cache_data_in;
    logic [511:0]  cache_cl_in;
    logic          cache_hit, cache_dirty, cache_valid;
    logic [17:0]   cache_tag_out;
    logic [31:0]   cache_data_out;
    logic [511:0]  cache_cl_out;
    logic          mem_rd_req, mem_wr_req;
    logic [31:0]   mem_addr;
    logic [511:0]  mem_wr_data, mem_rd_data;
    logic          mem_rd_valid, mem_wr_done;
`ifdef CPU_CACHE_STATS_EN
    logic [31:0]   hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    cpu_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .cache_en(cache_en), .cache_comp(cache_comp), .cache_wr(cache_wr),
        .cache_valid_in(cache_valid_in), .cache_replace_line(cache_replace_line),
        .cache_index(cache_index), .cache_offset(cache_offset), .cache_tag_in(cache_tag_in),
        .cache_data_in(cache_data_in), .cache_cl_in(cache_cl_in),
        .cache_hit(cache_hit), .cache_dirty(cache_dirty), .cache_valid(cache_valid),
        .cache_tag_out(cache_tag_out), .cache_data_out(cache_data_out), .cache_cl_out(cache_cl_out),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .mem_rd_valid(mem_rd_valid), .mem_wr_done(mem_wr_done)
`ifdef CPU_CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // Behavioural direct-mapped array: combinational lookup, writes on the clock edge.
    logic [511:0] l_m [256];
    logic [17:0]  t_m [256];
    logic         v_m [256];
    logic         d_m [256];
    logic         model_init;

    always_comb begin
        cache_valid    = v_m[cache_index];
        cache_dirty    = d_m[cache_index];
        cache_tag_out  = t_m[cache_index];
        cache_cl_out   = l_m[cache_index];
        cache_data_out = l_m[cache_index][{cache_offset[5:2], 5'b00000} +: 32];
        cache_hit      = cache_en && cache_comp && v_m[cache_index] && (t_m[cache_index] == cache_tag_in);
    end

    always @(posedge clk) begin
        if (model_init) begin
            for (int i = 0; i < 256; i++) begin
                v_m[i] <= 1'b0; d_m[i] <= 1'b0; t_m[i] <= '0; l_m[i] <= '0;
            end
        end else if (cache_en && cache_wr) begin
            if (cache_comp) begin
                if (cache_hit) begin
                    l_m[cache_index][{cache_offset[5:2], 5'b00000} +: 32] <= cache_data_in;
                    d_m[cache_index] <= 1'b1;
                end
            end else if (cache_replace_line) begin
                l_m[cache_index] <= cache_cl_in;
                t_m[cache_index] <= cache_tag_in;
                v_m[cache_index] <= cache_valid_in;
                d_m[cache_index] <= 1'b0;
            end
        end
    end

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int            r_lat, r_rd_first, r_wr_first, r_inst;
    logic          r_seen_rd, r_seen_wr;
    logic [31:0]   r_rd_addr, r_wr_addr;
    logic [511:0]  r_wr_line;

    // Entered just after a negedge; the next posedge is accept edge N, latency counted from it.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [511:0] line,
                          input int lrd, input int lwr);
        r_lat = -1; r_rd_first = -1; r_wr_first = -1; r_inst = 0;
        r_seen_rd = 1'b0; r_seen_wr = 1'b0;
        r_rd_addr = '0; r_wr_addr = '0; r_wr_line = '0;
        mem_rd_data = line;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            mem_rd_valid = 1'b0;
            mem_wr_done  = 1'b0;
            if (cache_replace_line) r_inst++;
            if (mem_wr_req) begin
                if (!r_seen_wr) begin
                    r_seen_wr = 1'b1; r_wr_first = k; r_wr_addr = mem_addr; r_wr_line = mem_wr_data;
                end
                if (k - r_wr_first == lwr) mem_wr_done = 1'b1;
            end
            if (mem_rd_req) begin
                if (!r_seen_rd) begin
                    r_seen_rd = 1'b1; r_rd_first = k; r_rd_addr = mem_addr;
                end
                if (k - r_rd_first == lrd) mem_rd_valid = 1'b1;
            end
            if (cpu_done) begin
                r_lat = k;
                cpu_rd = 1'b0; cpu_wr = 1'b0;
                break;
            end
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        mem_rd_valid = 1'b0; mem_wr_done = 1'b0;
        chk("request_completes", 64'(r_lat > 0), 64'd1);
    endtask

    logic [511:0] line_a, line_b, line_c;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; model_init = 1'b1;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_rd_data = '0; mem_rd_valid = 1'b0; mem_wr_done = 1'b0;
        line_a = '0; line_a[31:0] = 32'hDEAD_BEEF; line_a[63:32] = 32'h1111_1111;
        line_b = '0; line_b[31:0] = 32'h2222_2222; line_b[63:32] = 32'hCAFE_F00D;
        line_c = '0; line_c[31:0] = 32'h0BAD_F00D;
        repeat (3) @(negedge clk);

        chk("rst_cpu_done", 64'(cpu_done), 64'd0);
        chk("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        chk("rst_mem_req", 64'({mem_rd_req, mem_wr_req}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_cache_strobes", 64'({cache_en, cache_comp, cache_wr, cache_valid_in, cache_replace_line}), 64'd0);
        chk("rst_mem_wr_data", 64'(|mem_wr_data), 64'd0);
        chk("rst_cache_cl_in", 64'(|cache_cl_in), 64'd0);
`ifdef CPU_CACHE_STATS_EN
        chk("rst_counters", {hit_cnt, miss_cnt}, 64'd0);
`endif
        rst = 1'b0; model_init = 1'b0;
        @(negedge clk);

        // Cold load, Lrd = 3
        do_req(1'b1, 1'b0, 32'h0000_4040, 32'h0, line_a, 3, 0);
        chk("cold_latency", 64'(r_lat), 64'd8);
        chk("cold_rd_req", 64'({r_seen_rd, r_seen_wr}), 64'b10);
        chk("cold_rd_first", 64'(r_rd_first), 64'd2);
        chk("cold_mem_addr", 64'(r_rd_addr), 64'h0000_4040);
        chk("cold_installs", 64'(r_inst), 64'd1);
        chk("cold_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
`ifdef CPU_CACHE_STATS_EN
        chk("cold_counters", {hit_cnt, miss_cnt}, {32'd0, 32'd1});
`endif

        // Store hit, then load back
        do_req(1'b0, 1'b1, 32'h0000_4044, 32'h1234_5678, line_a, 0, 0);
        chk("store_latency", 64'(r_lat), 64'd2);
        chk("store_no_mem", 64'({r_seen_rd, r_seen_wr}), 64'b00);
        chk("store_rdata_kept", 64'(cpu_rdata), 64'hDEAD_BEEF);
`ifdef CPU_CACHE_STATS_EN
        chk("store_hit_cnt", 64'(hit_cnt), 64'd1);
`endif
        do_req(1'b1, 1'b0, 32'h0000_4047, 32'h0, line_a, 0, 0);
        chk("load_hit_latency", 64'(r_lat), 64'd2);
        chk("load_hit_rdata", 64'(cpu_rdata), 64'h1234_5678);

        // Dirty conflict miss, Lwr = 2, Lrd = 1
        do_req(1'b1, 1'b0, 32'h0000_8044, 32'h0, line_b, 1, 2);
        chk("dirty_seen", 64'({r_seen_rd, r_seen_wr}), 64'b11);
        chk("dirty_wr_addr", 64'(r_wr_addr), 64'h0000_4040);
        chk("dirty_wr_word1", 64'(r_wr_line[63:32]), 64'h1234_5678);
        chk("dirty_wr_word0", 64'(r_wr_line[31:0]), 64'hDEAD_BEEF);
        chk("dirty_order", {32'(r_wr_first), 32'(r_rd_first)}, {32'd2, 32'd5});
        chk("dirty_rd_addr", 64'(r_rd_addr), 64'h0000_8040);
        chk("dirty_latency", 64'(r_lat), 64'd9);
        chk("dirty_rdata", 64'(cpu_rdata), 64'hCAFE_F00D);
`ifdef CPU_CACHE_STATS_EN
        chk("dirty_counters", {hit_cnt, miss_cnt}, {32'd2, 32'd2});
`endif

        // Both strobes: treated as a store
        do_req(1'b1, 1'b1, 32'h0000_8048, 32'hA5A5_A5A5, line_b, 0, 0);
        chk("both_latency", 64'(r_lat), 64'd2);
        chk("both_rdata_kept", 64'(cpu_rdata), 64'hCAFE_F00D);
        do_req(1'b1, 1'b0, 32'h0000_8048, 32'h0, line_b, 0, 0);
        chk("both_readback", 64'(cpu_rdata), 64'hA5A5_A5A5);
`ifdef CPU_CACHE_STATS_EN
        chk("both_counters", {hit_cnt, miss_cnt}, {32'd4, 32'd2});
`endif

        // Reset while mem_rd_req is high
        mem_rd_data = line_c;
        cpu_rd = 1'b1; cpu_addr = 32'h0001_0080;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_rd_req) break;
        end
        chk("pre_rst_rd_req", 64'(mem_rd_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_mem_req", 64'({mem_rd_req, mem_wr_req}), 64'd0);
        chk("mid_rst_cpu_done", 64'(cpu_done), 64'd0);
        chk("mid_rst_strobes", 64'({cache_en, cache_comp, cache_wr, cache_valid_in, cache_replace_line}), 64'd0);
        chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
`ifdef CPU_CACHE_STATS_EN
        chk("mid_rst_counters", {hit_cnt, miss_cnt}, 64'd0);
`endif
        cpu_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_rd_valid = 1'b1;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        chk("stray_valid_ignored", 64'({mem_rd_req, cpu_done, cache_en}), 64'd0);
        @(negedge clk);
        chk("stray_valid_idle", 64'({mem_rd_req, cpu_done, cache_en}), 64'd0);

        do_req(1'b1, 1'b0, 32'h0001_0080, 32'h0, line_c, 2, 0);
        chk("post_rst_latency", 64'(r_lat), 64'd7);
        chk("post_rst_rd_addr", 64'(r_rd_addr), 64'h0001_0080);
        chk("post_rst_seen", 64'({r_seen_rd, r_seen_wr}), 64'b10);
        chk("post_rst_rdata", 64'(cpu_rdata), 64'h0BAD_F00D);
`ifdef CPU_CACHE_STATS_EN
        chk("post_rst_counters", {hit_cnt, miss_cnt}, {32'd0, 32'd1});
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
